ones_count_scheduler: RTL

Shares a single instance of the team's 127-bit combinational ones counter (`ones_counter_behavioural`, 127-bit word in, 7-bit count out) among REQS independent requesters. The block arbitrates with a round-robin pointer, captures the granted word, and registers the count. It then returns the count with the requester ID over a valid/ready response channel. It sits between the requester-side logic and the shared popcount datapath, so only one counter instance is instantiated system-wide.

---
 rtl/ones_count_scheduler_if.sv | 25 ++
 rtl/ones_count_scheduler.sv | 106 ++++++++++
 2 files changed

// File: rtl/ones_count_scheduler_if.sv
// Request/response bundle between requesters and the shared ones-count scheduler.
// master: requester/consumer side; slave: the scheduler.
interface ones_count_scheduler_if #(
    parameter int unsigned REQS = 4,
    parameter int unsigned IDW  = 2
);
    logic [REQS-1:0]     req_valid;
    logic [REQS*127-1:0] req_data;
    logic [REQS-1:0]     req_ready;
    logic                rsp_valid;
    logic                rsp_ready;
    logic [IDW-1:0]      rsp_id;
    logic [6:0]          rsp_count;
    logic                busy;

    modport master (
        output req_valid, req_data, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_count, busy
    );

    modport slave (
        input  req_valid, req_data, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_count, busy
    );
endinterface

// File: rtl/ones_count_scheduler.sv
// Time-shares one 127-bit ones counter among REQS requesters (IDLE -> COUNT -> RESP).
// Define ONES_SCHED_FIXED_PRIO_EN to replace round-robin with fixed lowest-index priority.
module ones_count_scheduler #(
    parameter int unsigned REQS = 4,
    parameter int unsigned IDW  = 2
) (
    input logic                   clk,
    input logic                   rst_n,
    ones_count_scheduler_if.slave bus
);
    localparam int unsigned W = 127;

    typedef enum logic [1:0] {StIdle, StCount, StResp} state_e;

    state_e          state_q, state_d;
    logic [W-1:0]    word_q;
    logic [IDW-1:0]  id_q;
    logic [6:0]      count_q;
    logic [6:0]      count_sum;
    logic [IDW-1:0]  grant;
    logic [IDW-1:0]  cand;
    logic            grant_valid;
    logic [REQS-1:0] ready;

`ifndef ONES_SCHED_FIXED_PRIO_EN
    logic [IDW-1:0] rr_ptr_q;
`endif

    // First valid requester in search order; the search order is the only build difference.
    always_comb begin
        grant_valid = 1'b0;
        grant       = '0;
        cand        = '0;
        for (int unsigned k = 0; k < REQS; k++) begin
`ifdef ONES_SCHED_FIXED_PRIO_EN
            cand = IDW'(k);
`else
            cand = IDW'((32'(rr_ptr_q) + k) % REQS);
`endif
            if (!grant_valid && bus.req_valid[cand]) begin
                grant_valid = 1'b1;
                grant       = cand;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        ready   = '0;
        unique case (state_q)
            StIdle: begin
                // Gated by rst_n so the strobe is low throughout reset.
                if (grant_valid && rst_n) begin
                    ready[grant] = 1'b1;
                    state_d      = StCount;
                end
            end
            StCount: state_d = StResp;
            StResp:  if (bus.rsp_ready) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Stand-in for the shared combinational ones counter, fed only by word_q.
    always_comb begin
        count_sum = '0;
        for (int i = 0; i < W; i++) begin
            count_sum = count_sum + {6'b0, word_q[i]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            word_q  <= '0;
            id_q    <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == StIdle && grant_valid) begin
                word_q <= bus.req_data[32'(grant) * W +: W];
                id_q   <= grant;
            end
            if (state_q == StCount) begin
                count_q <= count_sum;
            end
        end
    end

`ifndef ONES_SCHED_FIXED_PRIO_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q <= '0;
        end else if (state_q == StResp && bus.rsp_ready) begin
            rr_ptr_q <= (id_q == IDW'(REQS - 1)) ? '0 : id_q + 1'b1;
        end
    end
`endif

    assign bus.req_ready = ready;
    assign bus.rsp_valid = (state_q == StResp);
    assign bus.rsp_id    = id_q;
    assign bus.rsp_count = count_q;
    assign bus.busy      = (state_q != StIdle);

endmodule
